altr_hps_ckgate_ctrl: RTL and testbench



---
 rtl/altr_hps_ckgate_ctrl.sv | 103 ++++++++++
 tb/tb_altr_hps_ckgate_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/altr_hps_ckgate_ctrl.sv
// Idle-driven clock-gate controller: counts idle cycles, drops the registered
// gate enable, and runs a fixed settle sequence on wake before reporting ready.
module altr_hps_ckgate_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WAKE_DLY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             auto_en,
  input  logic [CNT_W-1:0] idle_thresh,
  input  logic             busy,
  input  logic             wake_req,
  output logic             ck_en,
  output logic             ready,
  output logic             wake_done,
  output logic [15:0]      gate_cnt
);

  typedef enum logic [1:0] {RUN, IDLE_CNT, GATED, WAKE} state_t;

  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_DLY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]       wake_cnt_q, wake_cnt_d;
  logic             ck_en_q, ck_en_d;
  logic             ready_q, ready_d;
  logic             wake_done_q, wake_done_d;
  logic [15:0]      gate_cnt_q, gate_cnt_d;
  logic             wake;

  assign wake = busy | wake_req | ~auto_en;

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    wake_done_d = 1'b0;
    gate_cnt_d  = gate_cnt_q;
    unique case (state_q)
      RUN: begin
        if (!wake) begin
          state_d    = IDLE_CNT;
          idle_cnt_d = idle_thresh;
        end
      end
      IDLE_CNT: begin
        // A wake coinciding with the final idle cycle wins over gating.
        if (wake) begin
          state_d = RUN;
        end else if (idle_cnt_q == '0) begin
          state_d = GATED;
          if (gate_cnt_q != '1) gate_cnt_d = gate_cnt_q + 16'd1;
        end else begin
          idle_cnt_d = idle_cnt_q - CNT_W'(1);
        end
      end
      GATED: begin
        if (wake) begin
          state_d    = WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      WAKE: begin
        if (wake_cnt_q == '0) begin
          state_d     = RUN;
          wake_done_d = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
    ck_en_d = (state_d != GATED);
    ready_d = (state_d == RUN) || (state_d == IDLE_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      ck_en_q     <= 1'b1;
      ready_q     <= 1'b1;
      wake_done_q <= 1'b0;
      gate_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      ck_en_q     <= ck_en_d;
      ready_q     <= ready_d;
      wake_done_q <= wake_done_d;
      gate_cnt_q  <= gate_cnt_d;
    end
  end

  assign ck_en     = ck_en_q;
  assign ready     = ready_q;
  assign wake_done = wake_done_q;
  assign gate_cnt  = gate_cnt_q;

endmodule

// File: tb/tb_altr_hps_ckgate_ctrl.sv
// Bench for altr_hps_ckgate_ctrl: directed scenarios plus random traffic,
// all compared against an elapsed-cycle reference model.
module tb_altr_hps_ckgate_ctrl;

  localparam int CNT_W    = 8;
  localparam int WAKE_DLY = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             auto_en;
  logic [CNT_W-1:0] idle_thresh;
  logic             busy;
  logic             wake_req;
  logic             ck_en;
  logic             ready;
  logic             wake_done;
  logic [15:0]      gate_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  altr_hps_ckgate_ctrl #(.CNT_W(CNT_W), .WAKE_DLY(WAKE_DLY)) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .idle_thresh(idle_thresh),
    .busy(busy), .wake_req(wake_req), .ck_en(ck_en), .ready(ready),
    .wake_done(wake_done), .gate_cnt(gate_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Reference model: tracks elapsed cycles in each phase rather than down-counters.
  typedef enum int {M_RUN, M_IDLE, M_GATED, M_WAKE} mmode_t;
  mmode_t m_mode;
  int     m_thr, m_seen, m_wseen, m_gcnt;
  bit     m_done;

  function automatic void model_reset();
    m_mode = M_RUN; m_thr = 0; m_seen = 0; m_wseen = 0; m_gcnt = 0; m_done = 0;
  endfunction

  function automatic void model_step();
    bit w;
    w = busy | wake_req | !auto_en;
    m_done = 0;
    case (m_mode)
      M_RUN:   if (!w) begin m_mode = M_IDLE; m_thr = int'(idle_thresh); m_seen = 0; end
      M_IDLE:  if (w) m_mode = M_RUN;
               else if (m_seen == m_thr) begin
                 m_mode = M_GATED;
                 m_gcnt = (m_gcnt < 65535) ? m_gcnt + 1 : 65535;
               end else m_seen++;
      M_GATED: if (w) begin m_mode = M_WAKE; m_wseen = 1; end
      M_WAKE:  if (m_wseen == WAKE_DLY) begin m_mode = M_RUN; m_done = 1; end
               else m_wseen++;
      default: m_mode = M_RUN;
    endcase
  endfunction

  function automatic logic [18:0] m_vec();
    return {m_mode != M_GATED, (m_mode == M_RUN) || (m_mode == M_IDLE), m_done, 16'(m_gcnt)};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {ck_en, ready, wake_done, gate_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset(input logic ae, input logic [CNT_W-1:0] thr);
    @(negedge clk);
    rst = 1'b1; auto_en = ae; idle_thresh = thr; busy = 1'b0; wake_req = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gated(output bit ok);
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      tick();
      ok = (m_mode == M_GATED);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; auto_en = 1'b1; idle_thresh = '0; busy = 1'b0; wake_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_vec() !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs_vec(), {1'b1, 1'b1, 1'b0, 16'h0000});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_gate();
    apply_reset(1'b1, 8'd3);
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if (obs_vec() !== m_vec()) begin
        n_fail++; $display("FAIL basic_gate edge %0d: got %h expected %h", i, obs_vec(), m_vec());
      end
      if (i == 4) begin
        n_checks++;
        if ({ck_en, ready} !== 2'b11) begin
          n_fail++; $display("FAIL basic_gate_last_idle: got %b expected 11", {ck_en, ready});
        end
      end
      if (i == 5) begin
        n_checks++;
        if ({ck_en, ready, gate_cnt} !== {2'b00, 16'd1}) begin
          n_fail++; $display("FAIL basic_gate_gated: got %h expected %h", {ck_en, ready, gate_cnt}, {2'b00, 16'd1});
        end
      end
    end
  endtask

  task automatic test_wake_pulse();
    logic [2:0] exp3;
    for (int e = 1; e <= 4; e++) begin
      wake_req = (e == 1);
      tick();
      exp3 = (e <= 2) ? 3'b100 : (e == 3) ? 3'b111 : 3'b110;
      n_checks++;
      if (obs_vec() !== m_vec() || {ck_en, ready, wake_done} !== exp3) begin
        n_fail++; $display("FAIL wake_pulse edge %0d: got %h/%b expected %h/%b", e, obs_vec(), {ck_en, ready, wake_done}, m_vec(), exp3);
      end
    end
    wake_req = 1'b0;
  endtask

  task automatic test_abort();
    apply_reset(1'b1, 8'd5);
    for (int c = 1; c <= 10; c++) begin
      busy = (c == 6);
      tick();
      n_checks++;
      if (obs_vec() !== m_vec() || ck_en !== 1'b1 || gate_cnt !== 16'd0) begin
        n_fail++; $display("FAIL abort edge %0d: got %h expected %h", c, obs_vec(), m_vec());
      end
    end
    busy = 1'b0;
  endtask

  task automatic test_thresh0_toggle();
    int gated_cycles = 0;
    apply_reset(1'b1, 8'd0);
    for (int c = 0; c < 40; c++) begin
      busy = ((c / 2) % 2) == 1;
      tick();
      if (m_mode == M_GATED) gated_cycles++;
      n_checks++;
      if (obs_vec() !== m_vec()) begin
        n_fail++; $display("FAIL thresh0_toggle edge %0d: got %h expected %h", c, obs_vec(), m_vec());
      end
    end
    busy = 1'b0;
    n_checks++;
    if (gate_cnt !== 16'(gated_cycles)) begin
      n_fail++; $display("FAIL thresh0_gate_count: got %0d expected %0d", gate_cnt, gated_cycles);
    end
  endtask

  task automatic test_auto_off();
    bit ok;
    logic [2:0] exp3;
    apply_reset(1'b1, 8'd2);
    wait_gated(ok);
    n_checks++;
    if (!ok || obs_vec() !== m_vec()) begin
      n_fail++; $display("FAIL auto_off_gate: got %h expected %h (reached=%0d)", obs_vec(), m_vec(), ok);
    end
    auto_en = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      exp3 = (e <= 2) ? 3'b100 : (e == 3) ? 3'b111 : 3'b110;
      n_checks++;
      if (obs_vec() !== m_vec() || {ck_en, ready, wake_done} !== exp3) begin
        n_fail++; $display("FAIL auto_off edge %0d: got %h/%b expected %h/%b", e, obs_vec(), {ck_en, ready, wake_done}, m_vec(), exp3);
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset(1'b1, 8'd0);
    force dut.gate_cnt_q = 16'hFFFE;
    #1;
    release dut.gate_cnt_q;
    m_gcnt = 65534;
    for (int c = 0; c < 30; c++) begin
      wake_req = (m_mode == M_GATED);
      tick();
      n_checks++;
      if (obs_vec() !== m_vec()) begin
        n_fail++; $display("FAIL saturate edge %0d: got %h expected %h", c, obs_vec(), m_vec());
      end
    end
    wake_req = 1'b0;
    n_checks++;
    if (gate_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL saturate_final: got %h expected ffff", gate_cnt);
    end
  endtask

  task automatic test_reset_mid_wake();
    bit ok;
    apply_reset(1'b1, 8'd0);
    wait_gated(ok);
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    n_checks++;
    if (!ok || obs_vec() !== m_vec() || {ck_en, ready} !== 2'b10) begin
      n_fail++; $display("FAIL mid_wake_entry: got %h expected %h (reached=%0d)", obs_vec(), m_vec(), ok);
    end
    #1 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL mid_wake_async_reset: got %h expected %h", obs_vec(), {1'b1, 1'b1, 1'b0, 16'h0000});
    end
    auto_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (obs_vec() !== m_vec() || wake_done !== 1'b0) begin
        n_fail++; $display("FAIL mid_wake_after_release edge %0d: got %h expected %h", e, obs_vec(), m_vec());
      end
    end
    apply_reset(1'b1, 8'd1);
    wait_gated(ok);
    #1 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (!ok || ck_en !== 1'b1 || ready !== 1'b1) begin
      n_fail++; $display("FAIL gated_async_reset: got ck_en=%b ready=%b expected 1/1 (reached=%0d)", ck_en, ready, ok);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    apply_reset(1'b1, 8'd0);
    for (int c = 0; c < 3000; c++) begin
      auto_en     = ($urandom % 8) != 0;
      busy        = ($urandom % 4) == 0;
      wake_req    = ($urandom % 16) == 0;
      idle_thresh = CNT_W'($urandom % 6);
      tick();
      n_checks++;
      if (obs_vec() !== m_vec()) begin
        n_fail++; $display("FAIL random cycle %0d: got %h expected %h", c, obs_vec(), m_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_gate();
    test_wake_pulse();
    test_abort();
    test_thresh0_toggle();
    test_auto_off();
    test_saturate();
    test_reset_mid_wake();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
